md_unit: RTL

- Parametrised iterative multiply/divide coprocessor for the pipelined core's execute stage.
- Replaces the fixed 32-bit multdiv with a WIDTH-generic unit.
- Adds a valid/ready handshake on both sides, four operation modes, a destination-tag passthrough, flush and back-to-back issue.
- The execute stage stalls fetch/decode while in_ready is low or a result is pending.

---
 rtl/md_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// Iterative signed multiply/divide: WIDTH+1 edges per op (divide-by-zero answers on the accept edge).
// Backpressure: a result holds in DONE until out_ready; a new op may be accepted on the drain edge.
module md_unit #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_exc,
   output logic [TAG_W-1:0] out_tag
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   count;
   logic [WIDTH:0]     hiReg;
   logic [WIDTH-1:0]   loReg;
   logic [WIDTH-1:0]   opB;
   logic [1:0]         opReg;
   logic               negRes;
   logic               negRem;
   logic               ovf;
   logic [TAG_W-1:0]   tagReg;

   logic               accept;
   logic               divZero;
   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;
   logic [WIDTH:0]     sumHi;
   logic [2*WIDTH:0]   mulShift;
   logic [WIDTH:0]     trial;
   logic [2*WIDTH-1:0] prodMag;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic               mulFits;
   logic [WIDTH-1:0]   finRes;
   logic               finExc;

   assign in_ready  = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign divZero   = in_op[1] && (in_b == '0);
   assign magA      = in_a[WIDTH-1] ? -in_a : in_a;
   assign magB      = in_b[WIDTH-1] ? -in_b : in_b;

   always_comb begin
      sumHi    = hiReg + {1'b0, (loReg[0] ? opB : {WIDTH{1'b0}})};
      mulShift = {sumHi, loReg} >> 1;
      // restoring divide: shift in next dividend bit, keep the difference if it did not borrow
      trial    = {hiReg[WIDTH-1:0], loReg[WIDTH-1]} - {1'b0, opB};
      prodMag  = {hiReg[WIDTH-1:0], loReg};
      prod     = negRes ? -prodMag : prodMag;
      quo      = negRes ? -loReg : loReg;
      rem      = negRem ? -hiReg[WIDTH-1:0] : hiReg[WIDTH-1:0];
      mulFits  = (&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]);
      finRes   = '0;
      finExc   = 1'b0;
      case (opReg)
         2'b00: begin finRes = prod[WIDTH-1:0];       finExc = !mulFits; end
         2'b01: begin finRes = prod[2*WIDTH-1:WIDTH]; finExc = 1'b0;     end
         2'b10: begin finRes = quo;                   finExc = ovf;      end
         default: begin finRes = rem;                 finExc = 1'b0;     end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         count      <= '0;
         hiReg      <= '0;
         loReg      <= '0;
         opB        <= '0;
         opReg      <= '0;
         negRes     <= 1'b0;
         negRem     <= 1'b0;
         ovf        <= 1'b0;
         tagReg     <= '0;
         out_result <= '0;
         out_exc    <= 1'b0;
         out_tag    <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else if (state == BUSY) begin
         if (count != '0) begin
            count <= count - CNT_W'(1);
            if (!opReg[1]) begin
               hiReg <= mulShift[2*WIDTH:WIDTH];
               loReg <= mulShift[WIDTH-1:0];
            end else begin
               hiReg <= trial[WIDTH] ? {hiReg[WIDTH-1:0], loReg[WIDTH-1]} : trial;
               loReg <= {loReg[WIDTH-2:0], ~trial[WIDTH]};
            end
         end else begin
            state      <= DONE;
            out_result <= finRes;
            out_exc    <= finExc;
            out_tag    <= tagReg;
         end
      end else if (accept) begin
         opReg  <= in_op;
         tagReg <= in_tag;
         negRes <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
         negRem <= in_a[WIDTH-1];
         ovf    <= (in_op == 2'b10) && (in_a == MIN_NEG) && (&in_b);
         hiReg  <= '0;
         opB    <= in_op[1] ? magB : magA;
         loReg  <= in_op[1] ? magA : magB;
         count  <= CNT_W'(WIDTH);
         if (divZero) begin
            state      <= DONE;
            out_result <= '0;
            out_exc    <= 1'b1;
            out_tag    <= in_tag;
         end else begin
            state <= BUSY;
         end
      end else if ((state == DONE) && out_ready) begin
         state <= IDLE;
      end
   end

endmodule
